// File: rtl/pdl_stack_ctl.sv
// Push-down-list controller: drives a 1Kx32 synchronous RAM for push/pop/peek/clear
// and returns pop/peek data over a valid/ready response channel.
module pdl_stack_ctl #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    input  logic [AW-1:0] cmd_index,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] address_a,
    output logic [DW-1:0] data_a,
    output logic          rden_a,
    output logic          wren_a,
    input  logic [DW-1:0] q_a,
    output logic [AW-1:0] pdl_ptr,
    output logic [AW:0]   depth,
    output logic          empty,
    output logic          full,
    output logic          err_overflow,
    output logic          err_underflow
);

    typedef enum logic [1:0] {IDLE, RD, RSP} state_t;
    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_PEEK, OP_CLEAR} op_t;

    state_t        state, state_next;
    op_t           op;
    logic          peek_ok;
    logic          rden_int, wren_int;

    assign op        = op_t'(cmd_op);
    assign peek_ok   = {1'b0, cmd_index} < depth;
    assign empty     = (depth == '0);
    assign full      = depth[AW];
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);

    // Strobes are masked by reset directly so an async reset never produces a RAM cycle.
    assign rden_a = rden_int && !reset;
    assign wren_a = wren_int && !reset;

    always_comb begin
        state_next = state;
        rden_int   = 1'b0;
        wren_int   = 1'b0;
        address_a  = '0;
        data_a     = '0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_PUSH: begin
                            if (!full) begin
                                wren_int  = 1'b1;
                                address_a = pdl_ptr + AW'(1);
                                data_a    = cmd_data;
                            end
                        end
                        OP_POP: begin
                            if (!empty) begin
                                rden_int   = 1'b1;
                                address_a  = pdl_ptr;
                                state_next = RD;
                            end else begin
                                state_next = RSP;
                            end
                        end
                        OP_PEEK: begin
                            if (peek_ok) begin
                                rden_int   = 1'b1;
                                address_a  = pdl_ptr - cmd_index;
                                state_next = RD;
                            end else begin
                                state_next = RSP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RD:      state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pdl_ptr       <= '1;
            depth         <= '0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        case (op)
                            OP_PUSH: begin
                                if (!full) begin
                                    pdl_ptr <= pdl_ptr + AW'(1);
                                    depth   <= depth + (AW+1)'(1);
                                end else begin
                                    err_overflow <= 1'b1;
                                end
                            end
                            OP_POP: begin
                                if (!empty) begin
                                    pdl_ptr <= pdl_ptr - AW'(1);
                                    depth   <= depth - (AW+1)'(1);
                                end else begin
                                    err_underflow <= 1'b1;
                                    rsp_data      <= '0;
                                    rsp_err       <= 1'b1;
                                end
                            end
                            OP_PEEK: begin
                                if (!peek_ok) begin
                                    rsp_data <= '0;
                                    rsp_err  <= 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                pdl_ptr       <= '1;
                                depth         <= '0;
                                err_overflow  <= 1'b0;
                                err_underflow <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                RD: begin
                    rsp_data <= q_a;
                    rsp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pdl_stack_ctl.sv
// Directed bench for pdl_stack_ctl with a behavioural 1Kx32 synchronous RAM.
module tb_pdl_stack_ctl;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] cmd_index;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] address_a;
    logic [DW-1:0] data_a;
    logic          rden_a;
    logic          wren_a;
    logic [DW-1:0] q_a;
    logic [AW-1:0] pdl_ptr;
    logic [AW:0]   depth;
    logic          empty, full, err_overflow, err_underflow;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wren_a) mem[address_a] <= data_a;
        if (rden_a) q_a <= mem[address_a];
    end

    pdl_stack_ctl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_index(cmd_index),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .address_a(address_a), .data_a(data_a), .rden_a(rden_a), .wren_a(wren_a), .q_a(q_a),
        .pdl_ptr(pdl_ptr), .depth(depth), .empty(empty), .full(full),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    // Present a command at the falling edge; returns with it still asserted, #1 later.
    task automatic drive(input logic [1:0] op, input logic [DW-1:0] d, input logic [AW-1:0] idx);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_index = idx;
        #1;
    endtask

    task automatic accept_edge();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    // Full pop/peek transaction; ok=0 if no response within the cycle budget.
    task automatic run_read(input logic [1:0] op, input logic [AW-1:0] idx,
                            output logic [DW-1:0] d, output logic e, output logic ok);
        drive(op, '0, idx);
        accept_edge();
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        d = rsp_data; e = rsp_err;
        if (ok) handshake();
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_index = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (pdl_ptr !== 10'h3FF) begin fails++; $display("FAIL reset_ptr got %h want 3ff", pdl_ptr); end
        tests++; if (depth !== 11'd0) begin fails++; $display("FAIL reset_depth got %0d want 0", depth); end
        tests++; if ({empty, full} !== 2'b10) begin fails++; $display("FAIL reset_empty_full got %b want 10", {empty, full}); end
        tests++; if ({rsp_valid, rsp_err, rden_a, wren_a} !== 4'b0000) begin fails++; $display("FAIL reset_ctl got %b want 0000", {rsp_valid, rsp_err, rden_a, wren_a}); end
        tests++; if (rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
        tests++; if ({err_overflow, err_underflow} !== 2'b00) begin fails++; $display("FAIL reset_errs got %b want 00", {err_overflow, err_underflow}); end
        @(negedge clk); reset = 1'b0;
        #1;
        tests++; if ({cmd_ready, address_a} !== {1'b1, 10'h000}) begin fails++; $display("FAIL idle_drive got %b/%h want 1/000", cmd_ready, address_a); end
    endtask

    task automatic test_push3();
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 32'hA0000001 + DW'(i), '0);
            tests++;
            if ({wren_a, rden_a, address_a, data_a} !== {2'b10, AW'(i), 32'hA0000001 + DW'(i)}) begin
                fails++; $display("FAIL push3_strobe%0d got w%b r%b a%h d%h want w1 r0 a%h", i, wren_a, rden_a, address_a, data_a, i);
            end
            accept_edge();
        end
        tests++; if (depth !== 11'd3) begin fails++; $display("FAIL push3_depth got %0d want 3", depth); end
        tests++; if (pdl_ptr !== 10'd2) begin fails++; $display("FAIL push3_ptr got %h want 002", pdl_ptr); end
    endtask

    task automatic test_pop_hold();
        drive(2'b01, '0, '0);
        tests++; if ({rden_a, wren_a, address_a} !== {2'b10, 10'd2}) begin fails++; $display("FAIL pop_strobe got r%b w%b a%h want r1 w0 a002", rden_a, wren_a, address_a); end
        accept_edge();
        tests++; if ({rsp_valid, cmd_ready} !== 2'b00) begin fails++; $display("FAIL pop_rd_state got v%b rdy%b want 00", rsp_valid, cmd_ready); end
        tests++; if ({pdl_ptr, depth} !== {10'd1, 11'd2}) begin fails++; $display("FAIL pop_ptr_depth got %h/%0d want 001/2", pdl_ptr, depth); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({rsp_valid, cmd_ready, rsp_err, rsp_data} !== {3'b100, 32'hA0000003}) begin
                fails++; $display("FAIL pop_hold%0d got v%b rdy%b e%b d%h want v1 rdy0 e0 dA0000003", i, rsp_valid, cmd_ready, rsp_err, rsp_data);
            end
        end
        handshake();
        tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin fails++; $display("FAIL pop_release got v%b rdy%b want 01", rsp_valid, cmd_ready); end
    endtask

    task automatic test_peek();
        logic [DW-1:0] d; logic e, ok;
        drive(2'b10, '0, 10'd1);
        tests++; if ({rden_a, address_a} !== {1'b1, 10'd0}) begin fails++; $display("FAIL peek_strobe got r%b a%h want r1 a000", rden_a, address_a); end
        accept_edge();
        @(posedge clk); #1;
        tests++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'hA0000001}) begin fails++; $display("FAIL peek1_rsp got v%b e%b d%h want v1 e0 dA0000001", rsp_valid, rsp_err, rsp_data); end
        handshake();
        tests++; if ({pdl_ptr, depth} !== {10'd1, 11'd2}) begin fails++; $display("FAIL peek1_state got %h/%0d want 001/2", pdl_ptr, depth); end
        drive(2'b10, '0, 10'd2);
        tests++; if ({rden_a, wren_a} !== 2'b00) begin fails++; $display("FAIL peek2_nostrobe got r%b w%b want 00", rden_a, wren_a); end
        accept_edge();
        tests++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'h0}) begin fails++; $display("FAIL peek2_rsp got v%b e%b d%h want v1 e1 d0", rsp_valid, rsp_err, rsp_data); end
        tests++; if ({err_overflow, err_underflow} !== 2'b00) begin fails++; $display("FAIL peek2_flags got %b want 00", {err_overflow, err_underflow}); end
        handshake();
        run_read(2'b01, '0, d, e, ok);
        tests++; if ({ok, e, d} !== {2'b10, 32'hA0000002}) begin fails++; $display("FAIL drain_pop1 got ok%b e%b d%h want ok1 e0 dA0000002", ok, e, d); end
        run_read(2'b01, '0, d, e, ok);
        tests++; if ({ok, e, d} !== {2'b10, 32'hA0000001}) begin fails++; $display("FAIL drain_pop2 got ok%b e%b d%h want ok1 e0 dA0000001", ok, e, d); end
    endtask

    task automatic test_underflow_clear();
        drive(2'b01, '0, '0);
        tests++; if ({rden_a, wren_a, empty} !== 3'b001) begin fails++; $display("FAIL upop_strobe got r%b w%b empty%b want 001", rden_a, wren_a, empty); end
        accept_edge();
        tests++; if ({rsp_valid, rsp_err, rsp_data, err_underflow} !== {2'b11, 32'h0, 1'b1}) begin fails++; $display("FAIL upop_rsp got v%b e%b d%h uf%b want v1 e1 d0 uf1", rsp_valid, rsp_err, rsp_data, err_underflow); end
        handshake();
        drive(2'b00, 32'h55AA55AA, '0);
        accept_edge();
        tests++; if ({pdl_ptr, depth, err_underflow} !== {10'd0, 11'd1, 1'b1}) begin fails++; $display("FAIL pre_clear got %h/%0d uf%b want 000/1 uf1", pdl_ptr, depth, err_underflow); end
        drive(2'b11, '0, '0);
        tests++; if ({rden_a, wren_a} !== 2'b00) begin fails++; $display("FAIL clear_strobe got r%b w%b want 00", rden_a, wren_a); end
        accept_edge();
        tests++; if ({pdl_ptr, depth, err_underflow, empty} !== {10'h3FF, 11'd0, 2'b01}) begin fails++; $display("FAIL clear_state got %h/%0d uf%b e%b want 3ff/0 uf0 e1", pdl_ptr, depth, err_underflow, empty); end
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] d; logic e, ok;
        for (int i = 0; i < 1024; i++) begin
            drive(2'b00, DW'(i), '0);
            tests++;
            if ({wren_a, address_a} !== {1'b1, AW'(i)}) begin fails++; $display("FAIL fill%0d got w%b a%h want w1 a%h", i, wren_a, address_a, i); end
            accept_edge();
        end
        tests++; if ({full, depth, pdl_ptr} !== {1'b1, 11'd1024, 10'h3FF}) begin fails++; $display("FAIL fill_full got f%b %0d %h want f1 1024 3ff", full, depth, pdl_ptr); end
        drive(2'b00, 32'hDEADBEEF, '0);
        tests++; if (wren_a !== 1'b0) begin fails++; $display("FAIL ovf_strobe got w%b want 0", wren_a); end
        accept_edge();
        tests++; if ({err_overflow, depth, rsp_valid} !== {1'b1, 11'd1024, 1'b0}) begin fails++; $display("FAIL ovf_state got of%b %0d v%b want of1 1024 v0", err_overflow, depth, rsp_valid); end
        drive(2'b10, '0, 10'd1023);
        tests++; if ({rden_a, address_a} !== {1'b1, 10'h000}) begin fails++; $display("FAIL peek_deep got r%b a%h want r1 a000", rden_a, address_a); end
        accept_edge();
        @(posedge clk); #1;
        tests++; if ({rsp_valid, rsp_data} !== {1'b1, 32'h0}) begin fails++; $display("FAIL peek_deep_rsp got v%b d%h want v1 d0", rsp_valid, rsp_data); end
        handshake();
        for (int i = 0; i < 1024; i++) begin
            run_read(2'b01, '0, d, e, ok);
            tests++;
            if ({ok, e, d} !== {2'b10, DW'(1023 - i)}) begin fails++; $display("FAIL drain%0d got ok%b e%b d%h want ok1 e0 d%h", i, ok, e, d, 1023 - i); end
        end
        tests++; if ({empty, depth} !== {1'b1, 11'd0}) begin fails++; $display("FAIL drain_empty got e%b %0d want e1 0", empty, depth); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d; logic e, ok;
        drive(2'b00, 32'h12345678, '0);
        accept_edge();
        drive(2'b01, '0, '0);
        accept_edge();
        #2 reset = 1'b1;
        #1;
        tests++; if ({rsp_valid, cmd_ready, rden_a, wren_a} !== 4'b0100) begin fails++; $display("FAIL rst_mid got v%b rdy%b r%b w%b want 0100", rsp_valid, cmd_ready, rden_a, wren_a); end
        @(posedge clk); #1;
        tests++; if ({rsp_valid, rden_a, wren_a, depth} !== {3'b000, 11'd0}) begin fails++; $display("FAIL rst_hold got v%b r%b w%b %0d want 000 0", rsp_valid, rden_a, wren_a, depth); end
        @(negedge clk); reset = 1'b0;
        run_read(2'b01, '0, d, e, ok);
        tests++; if ({ok, e, d} !== {2'b11, 32'h0}) begin fails++; $display("FAIL rst_pop got ok%b e%b d%h want ok1 e1 d0", ok, e, d); end
    endtask

    initial begin
        test_reset();
        test_push3();
        test_pop_hold();
        test_peek();
        test_underflow_clear();
        test_fill_drain();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pdl_stack_ctl.md
# pdl_stack_ctl

Push-down-list controller: the initiator side of the 1Kx32 synchronous PDL RAM. It turns push/pop/indexed-read/clear commands from the datapath into RAM address and strobe cycles. It maintains the PDL pointer and depth, absorbs the RAM's one-cycle read latency, and returns read data over a valid/ready response channel. It also flags overflow and underflow.

## Interface
Parameters:
- AW, 10, RAM address width; stack depth is 2^AW (1024).
- DW, 32, data width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller accepts a command this cycle.
- cmd_op  in  2  00 push, 01 pop, 10 indexed read (peek), 11 clear.
- cmd_data  in  DW  push data.
- cmd_index  in  AW  peek offset below top of stack (0 = top).
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  DW  data for pop/peek.
- rsp_err  out  1  response is an error (empty pop, out-of-range peek).
- address_a  out  AW  RAM address.
- data_a  out  DW  RAM write data.
- rden_a  out  1  RAM read enable.
- wren_a  out  1  RAM write enable.
- q_a  in  DW  RAM read data, valid the cycle after the rden_a edge.
- pdl_ptr  out  AW  address of the top-of-stack entry.
- depth  out  AW+1  entries held, 0..1024.
- empty, full  out  1 each  depth==0, depth==1024.
- err_overflow, err_underflow  out  1 each  sticky error flags.

## Operation
- States: IDLE, RD (RAM read in flight), RSP (holding response). `cmd_ready` = (state==IDLE). A command is accepted on an edge where cmd_valid && cmd_ready.
- RAM drive is combinational from the accepted command. `rden_a`/`wren_a` are forced to 0 while reset is high. `address_a`/`data_a` are don't-care when no strobe is active, but are driven 0 in IDLE when no command is present.
- Push, not full:
  - wren_a=1, address_a=pdl_ptr+1 (mod 1024), data_a=cmd_data.
  - On the edge: pdl_ptr+=1, depth+=1. Stay in IDLE.
- Push, full: no RAM strobe, err_overflow<=1, pointer and depth unchanged. Stay in IDLE. No response is generated.
- Pop, not empty:
  - rden_a=1, address_a=pdl_ptr.
  - On the edge: pdl_ptr-=1, depth-=1, go to RD.
- Pop, empty: no strobe, err_underflow<=1. Go directly to RSP with rsp_data=0, rsp_err=1.
- Peek, cmd_index < depth:
  - rden_a=1, address_a=pdl_ptr-cmd_index (mod 1024).
  - Pointer and depth unchanged. Go to RD.
- Peek, cmd_index >= depth: no strobe. Go to RSP with rsp_data=0, rsp_err=1. Error flags are not affected.
- Clear: pdl_ptr<=all ones, depth<=0, both error flags<=0. No strobe. Stay in IDLE.
- RD: unconditionally register q_a into rsp_data, rsp_err<=0, go to RSP.
- RSP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready, go to IDLE.
- Pointer arithmetic is modulo 2^AW; depth is AW+1 bits and saturation is prevented by the full/empty checks.

## Timing
- Reset values (asynchronous):
  - state IDLE, pdl_ptr=10'h3FF, depth=0, empty=1, full=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0, err flags=0.
  - rden_a=wren_a=0.
- Push throughput: one per cycle, back-to-back. The RAM is written on the acceptance edge.
- Pop/peek latency:
  - Accepted at edge N; q_a is valid after edge N.
  - rsp_data is registered at edge N+1, so rsp_valid is high from cycle N+1.
  - Earliest next command is the cycle after the rsp handshake edge.
- Error pop/peek: rsp_valid is high in the cycle after acceptance.
- pdl_ptr, depth, empty, full and the error flags update on the acceptance edge.
- Wrap-around: pushes from ptr 0x3FF write address 0x000. A peek across the 0 boundary wraps; for example, ptr=1 with index 3 reads address 0x3FE.
- Reset mid-operation (RD or RSP): the response is discarded and rsp_valid drops immediately. Reset must not produce any RAM strobe.

## Test plan
- After reset, push 0xA0000001, 0xA0000002, 0xA0000003 on consecutive cycles -> wren_a at addresses 0,1,2; depth=3; pdl_ptr=2.
- Then pop -> rden_a at address 2, rsp_valid one cycle later with rsp_data=0xA0000003, rsp_err=0. Hold rsp_ready=0 for 3 cycles -> rsp_data stable and cmd_ready=0 throughout.
- Peek with index 1 at depth 2 -> rsp_data=0xA0000001, depth unchanged. Peek with index 2 -> rsp_err=1, rsp_data=0, no rden_a.
- Pop with empty=1 -> no strobe, err_underflow=1, error response. Then clear -> err_underflow=0, pdl_ptr=0x3FF.
- 1024 pushes of value i -> full=1, last write at address 0x3FF. A 1025th push -> no wren_a, err_overflow=1, depth=1024. Then 1024 pops -> values 1023..0 in order, empty=1.
- Assert reset while in RD -> rsp_valid=0 and state IDLE with no further strobe. A pop after reset returns an error response.
